// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_rx_pkg: constants and state encoding shared by the receiver,
// the matching transmitter and the parity checker benches.
package serial_frame_rx_pkg;
    localparam int   FRAME_DATA_BITS = 8;
    localparam logic LINE_IDLE       = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;
endpackage

// File: rtl/serial_frame_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous input bit.
// Ports: clk, rst_n (async, active-low), d (async input), q (synchronised).
// RST_VAL sets the value both flops take in reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start + 8 data (LSB first) + parity + stop frames,
// validates framing and hands data/parity_bit on to the downstream checker.
// Ports: clk, rst_n (async, active-low), rx (async serial line, idle high),
// data/parity_bit (last good frame), frame_valid / framing_err (1-cycle
// pulses after the stop sample), busy (receiver not idle).
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    output logic [FRAME_DATA_BITS-1:0] data,
    output logic                       parity_bit,
    output logic                       frame_valid,
    output logic                       framing_err,
    output logic                       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

    logic                       rx_s;
    rx_state_e                  state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0]                 bit_q, bit_d;
    logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
    logic                       par_q, par_d;
    logic [FRAME_DATA_BITS-1:0] data_q, data_d;
    logic                       parity_bit_q, parity_bit_d;
    logic                       frame_valid_q, frame_valid_d;
    logic                       framing_err_q, framing_err_d;
    logic                       busy_q, busy_d;
    logic                       tick;
    logic                       stop_tick;

    sync_2ff #(.RST_VAL(LINE_IDLE)) u_sync_rx (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // START waits half a bit to land on the start midpoint; later states
    // then sample a full bit period apart, i.e. at each bit's midpoint.
    assign tick      = cnt_q == (state_q == START ? HALF_LAST : BIT_LAST);
    assign stop_tick = state_q == STOP && tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            data_q        <= '0;
            parity_bit_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            data_q        <= data_d;
            parity_bit_q  <= parity_bit_d;
            frame_valid_q <= frame_valid_d;
            framing_err_q <= framing_err_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = rx_s != LINE_IDLE ? START : IDLE;
            START:   state_d = !tick ? START : rx_s == LINE_IDLE ? IDLE : DATA;
            DATA:    state_d = tick && bit_q == LAST_BIT ? PARITY : DATA;
            PARITY:  state_d = tick ? STOP : PARITY;
            STOP:    state_d = !tick ? STOP : rx_s == LINE_IDLE ? IDLE : BREAK;
            BREAK:   state_d = rx_s == LINE_IDLE ? IDLE : BREAK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = (state_q == IDLE || state_q == BREAK || tick) ? '0 : cnt_q + 1'b1;
        bit_d   = state_q == IDLE ? 3'd0 : (state_q == DATA && tick) ? bit_q + 3'd1 : bit_q;
        shift_d = shift_q;
        if (state_q == DATA && tick)
            shift_d[bit_q] = rx_s;
        par_d         = (state_q == PARITY && tick) ? rx_s : par_q;
        frame_valid_d = stop_tick && rx_s;
        framing_err_d = stop_tick && !rx_s;
        data_d        = frame_valid_d ? shift_q : data_q;
        parity_bit_d  = frame_valid_d ? par_q : parity_bit_q;
        // Including the current state keeps busy high through the pulse cycle.
        busy_d        = state_q != IDLE || state_d != IDLE;
    end

    assign data        = data_q;
    assign parity_bit  = parity_bit_q;
    assign frame_valid = frame_valid_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed self-checking bench for serial_frame_rx.
module tb_serial_frame_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       parity_bit;
    logic       frame_valid;
    logic       framing_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int last_fv_cyc = 0;
    int prev_fv_cyc = 0;
    int fall_cyc = 0;
    int overlap = 0;
    int long_pulse = 0;
    logic fv_prev = 1'b0;
    logic fe_prev = 1'b0;
    logic [7:0] data_log [0:15];
    int base;

    serial_frame_rx #(.CLKS_PER_BIT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .data        (data),
        .parity_bit  (parity_bit),
        .frame_valid (frame_valid),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            data_log[fv_cnt[3:0]] = data;
            fv_cnt = fv_cnt + 1;
            prev_fv_cyc = last_fv_cyc;
            last_fv_cyc = cyc;
        end
        if (framing_err) fe_cnt = fe_cnt + 1;
        if (frame_valid && framing_err) overlap = overlap + 1;
        if ((frame_valid && fv_prev) || (framing_err && fe_prev)) long_pulse = long_pulse + 1;
        fv_prev = frame_valid;
        fe_prev = framing_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        fall_cyc = cyc;
        rx = 1'b0;
        cycles(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(16);
        end
        rx = p;
        cycles(16);
        rx = s;
        cycles(16);
        rx = 1'b1;
    endtask

    initial begin
        cycles(4);
        check("rst_data", data, 8'h00);
        check("rst_par", parity_bit, 1'b0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_fe", framing_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cycles(5);

        send_frame(8'hA5, 1'b0, 1'b1);
        cycles(10);
        check("good_fv_cnt", fv_cnt, 1);
        check("good_fe_cnt", fe_cnt, 0);
        check("good_data", data, 8'hA5);
        check("good_par", parity_bit, 1'b0);
        check("good_latency", last_fv_cyc - fall_cyc, 171);
        check("good_idle", busy, 1'b0);

        send_frame(8'h0F, 1'b1, 1'b1);
        cycles(10);
        check("pt_fv_cnt", fv_cnt, 2);
        check("pt_data", data, 8'h0F);
        check("pt_par", parity_bit, 1'b1);
        check("pt_even_err", (^data) ^ parity_bit, 1'b1);

        rx = 1'b0;
        cycles(3);
        rx = 1'b1;
        cycles(3);
        check("gl_busy_hi", busy, 1'b1);
        cycles(30);
        check("gl_busy_lo", busy, 1'b0);
        check("gl_fv_cnt", fv_cnt, 2);
        check("gl_fe_cnt", fe_cnt, 0);
        check("gl_data", data, 8'h0F);

        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        cycles(200);
        check("brk_fe_cnt", fe_cnt, 1);
        check("brk_fv_cnt", fv_cnt, 2);
        check("brk_data", data, 8'h0F);
        check("brk_par", parity_bit, 1'b1);
        check("brk_busy", busy, 1'b1);
        rx = 1'b1;
        cycles(10);
        check("brk_release", busy, 1'b0);
        check("brk_fe_after", fe_cnt, 1);

        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        cycles(10);
        check("b2b_fv_cnt", fv_cnt, 4);
        check("b2b_gap", last_fv_cyc - prev_fv_cyc, 176);
        check("b2b_first", data_log[2], 8'h00);
        check("b2b_second", data_log[3], 8'hFF);
        check("b2b_data", data, 8'hFF);

        rx = 1'b0;
        cycles(16);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            cycles(16);
        end
        rx = 1'b0;
        cycles(8);
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_data", data, 8'h00);
        check("mr_par", parity_bit, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_fv", frame_valid, 1'b0);
        base = fv_cnt;
        cycles(5);
        rx = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(200);
        check("mr_no_pulse", fv_cnt - base, 0);
        check("mr_fe_cnt", fe_cnt, 1);
        send_frame(8'h81, 1'b0, 1'b1);
        cycles(10);
        check("mr_fv_cnt", fv_cnt - base, 1);
        check("mr_rx_data", data, 8'h81);
        check("mr_rx_par", parity_bit, 1'b0);

        check("overlap", overlap, 0);
        check("long_pulse", long_pulse, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
